// File: rtl/serial_tx_ctrl_pkg.sv
// Shared types and constants for the serial transmit controller.
package serial_tx_pkg;

  localparam int BYTE_W = 8;
  localparam logic SOUT_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// Byte handshake between a producer and the serial transmit controller.
interface serial_tx_ctrl_if;
  import serial_tx_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/serial_tx_ctrl_shiftreg.sv
// 8-bit shift register: synchronous load, shift left with sin entering bit 0.
module shiftreg
  import serial_tx_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] d,
  input  logic              sin,
  output logic [BYTE_W-1:0] q
);

  // Load has priority over shift; contents hold otherwise.
  // NOTE: no reset here on purpose -- the controller forces a load of zero
  // while rst_n is low, so the datapath register needs no reset net.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[BYTE_W-2:0], sin};
    end
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serial transmit controller: shifts a byte out MSB first, CLKS_PER_BIT
// cycles per bit, while sampling sin into the same register (full duplex).
// Optional feature: define SERIAL_TX_CTRL_PARITY_EN to append an even
// parity bit after the data bits.
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_tx_ctrl_if.slave   bus,
  input  logic              sin,
  output logic              sout,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rx_data
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bit_cnt_q;
  logic [BYTE_W-1:0] sh_q;
  logic [BYTE_W-1:0] sh_d;
  logic              sh_load;
  logic              sh_shift;
  logic              transfer;
  logic              bit_end;
`ifdef SERIAL_TX_CTRL_PARITY_EN
  logic              parity_q;
`endif

  assign transfer = bus.in_valid && bus.in_ready;
  assign bit_end  = (div_q == DIV_LAST);

  // Shift register control: zero-load in reset, byte load on transfer,
  // shift at the end of each data bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_d     = '0;
    if (!rst_n) begin
      sh_load = 1'b1;
    end else if (transfer) begin
      sh_load = 1'b1;
      sh_d    = bus.in_data;
    end else if (state_q == ST_SHIFT && bit_end) begin
      sh_shift = 1'b1;
    end
  end

  shiftreg u_shiftreg (
    .clk   (clk),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (sh_d),
    .sin   (sin),
    .q     (sh_q)
  );

  // Frame sequencing: bit timing, bit counting and receive capture.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      rx_data   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            state_q   <= ST_SHIFT;
            div_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (bit_end) begin
            div_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
`ifdef SERIAL_TX_CTRL_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_DONE;
`endif
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
`ifdef SERIAL_TX_CTRL_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            div_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
`endif
        ST_DONE: begin
          rx_data   <= sh_q;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_TX_CTRL_PARITY_EN
  // Parity of the byte as accepted; held for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (transfer) begin
      parity_q <= ^bus.in_data;
    end
  end
`endif

  // Outputs decoded from the state; line idles high outside data bits.
  always_comb begin
    bus.in_ready = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    sout         = SOUT_IDLE;
    case (state_q)
      ST_SHIFT:  sout = sh_q[BYTE_W-1];
`ifdef SERIAL_TX_CTRL_PARITY_EN
      ST_PARITY: sout = parity_q;
`endif
      default:   sout = SOUT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: three instances (4, 1 and 2
// clocks per bit) against a frame-level reference model.
module tb_serial_tx_ctrl;

  localparam int CPB [3] = '{4, 1, 2};
`ifdef SERIAL_TX_CTRL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_n;
  logic [2:0]      in_valid;
  logic [2:0][7:0] in_data_v;
  logic [2:0]      sin_drv;
  logic [2:0]      loop;
  logic [2:0]      in_ready;
  logic [2:0]      sout;
  logic [2:0]      busy;
  logic [2:0]      done;
  logic [2:0]      sin_w;
  logic [2:0][7:0] rx_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_tx_ctrl_if bus ();
    assign bus.in_valid = in_valid[g];
    assign bus.in_data  = in_data_v[g];
    assign in_ready[g]  = bus.in_ready;
    assign sin_w[g]     = loop[g] ? sout[g] : sin_drv[g];

    serial_tx_ctrl #(.CLKS_PER_BIT(CPB[g])) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .bus     (bus),
      .sin     (sin_w[g]),
      .sout    (sout[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rx_data (rx_v[g])
    );
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] rx_exp [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame: mode 0 = sin tied low, 1 = random sin, 2 = loopback.
  // With hold set, in_valid stays high and in_data switches to nb right
  // after the transfer, so the next byte is offered throughout the frame.
  task automatic run_frame(input int idx, input logic [7:0] b, input int mode,
                           input bit hold, input logic [7:0] nb);
    int cpb = CPB[idx];
    int par_len = PAR_EN ? cpb : 0;
    logic [7:0] rx_model = 8'h00;
    logic exp_sout;
    logic r;
    check($sformatf("u%0d idle in_ready", idx), 32'(in_ready[idx]), 32'd1);
    check($sformatf("u%0d idle busy", idx), 32'(busy[idx]), 32'd0);
    check($sformatf("u%0d idle sout", idx), 32'(sout[idx]), 32'd1);
    loop[idx]      = (mode == 2);
    sin_drv[idx]   = 1'b0;
    in_valid[idx]  = 1'b1;
    in_data_v[idx] = b;
    step();
    if (hold) in_data_v[idx] = nb;
    else      in_valid[idx]  = 1'b0;
    for (int k = 0; k < 8 * cpb + par_len; k++) begin
      exp_sout = (k < 8 * cpb) ? b[7 - k / cpb] : ^b;
      check($sformatf("u%0d b%02h c%0d sout", idx, b, k), 32'(sout[idx]), 32'(exp_sout));
      check($sformatf("u%0d b%02h c%0d busy", idx, b, k), 32'(busy[idx]), 32'd1);
      check($sformatf("u%0d b%02h c%0d in_ready", idx, b, k), 32'(in_ready[idx]), 32'd0);
      check($sformatf("u%0d b%02h c%0d done", idx, b, k), 32'(done[idx]), 32'd0);
      check($sformatf("u%0d b%02h c%0d rx hold", idx, b, k), 32'(rx_v[idx]), 32'(rx_exp[idx]));
      if (mode == 0)      r = 1'b0;
      else if (mode == 2) r = exp_sout;
      else                r = 1'($urandom_range(0, 1));
      if (mode != 2) sin_drv[idx] = r;
      if (k < 8 * cpb && (k % cpb) == cpb - 1) rx_model = {rx_model[6:0], r};
      step();
    end
    check($sformatf("u%0d b%02h done pulse", idx, b), 32'(done[idx]), 32'd1);
    check($sformatf("u%0d b%02h done sout", idx, b), 32'(sout[idx]), 32'd1);
    check($sformatf("u%0d b%02h done busy", idx, b), 32'(busy[idx]), 32'd1);
    step();
    rx_exp[idx] = rx_model;
    check($sformatf("u%0d b%02h rx_data", idx, b), 32'(rx_v[idx]), 32'(rx_exp[idx]));
    check($sformatf("u%0d b%02h done clear", idx, b), 32'(done[idx]), 32'd0);
  endtask

  initial begin
    int idx, pidx, mode;
    bit hold, pend;
    logic [7:0] b, nb, pb;

    rst_n     = '0;
    in_valid  = '0;
    in_data_v = '0;
    sin_drv   = '0;
    loop      = '0;
    for (int i = 0; i < 3; i++) rx_exp[i] = 8'h00;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d reset sout", i), 32'(sout[i]), 32'd1);
      check($sformatf("u%0d reset busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d reset done", i), 32'(done[i]), 32'd0);
      check($sformatf("u%0d reset rx", i), 32'(rx_v[i]), 32'd0);
      check($sformatf("u%0d reset in_ready", i), 32'(in_ready[i]), 32'd1);
    end
    rst_n = '1;

    // A5 at 4 clocks/bit with sin low; nothing received.
    run_frame(0, 8'hA5, 0, 1'b0, 8'h00);
    check("a5 rx zero", 32'(rx_v[0]), 32'h00);

    // 3C at 1 clock/bit looped back comes home unchanged.
    run_frame(1, 8'h3C, 2, 1'b0, 8'h00);
    check("3c loopback rx", 32'(rx_v[1]), 32'h3C);

    // Back-to-back with in_valid held high.
    run_frame(0, 8'h01, 1, 1'b1, 8'h02);
    run_frame(0, 8'h02, 1, 1'b0, 8'h00);

    // Abort during bit 3 of FF; preload rx_data with a nonzero value first.
    run_frame(0, 8'h5A, 2, 1'b0, 8'h00);
    check("5a loopback rx", 32'(rx_v[0]), 32'h5A);
    in_valid[0]  = 1'b1;
    in_data_v[0] = 8'hFF;
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3 * CPB[0] + 1; k++) begin
      check($sformatf("abort c%0d done", k), 32'(done[0]), 32'd0);
      step();
    end
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    rx_exp[0] = 8'h00;
    check("abort sout", 32'(sout[0]), 32'd1);
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort done", 32'(done[0]), 32'd0);
    check("abort rx", 32'(rx_v[0]), 32'h00);
    check("abort in_ready", 32'(in_ready[0]), 32'd1);
    run_frame(0, 8'hC3, 1, 1'b0, 8'h00);

    // 07 at 2 clocks/bit; parity bit included when that build is selected.
    run_frame(2, 8'h07, 0, 1'b0, 8'h00);

    // Random frames across all three instances.
    pend = 1'b0;
    pidx = 0;
    pb   = 8'h00;
    for (int n = 0; n < 40; n++) begin
      if (pend) begin
        idx = pidx;
        b   = pb;
      end else begin
        idx = int'($urandom_range(0, 2));
        b   = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
      end
      mode = int'($urandom_range(1, 2));
      hold = ($urandom_range(0, 3) == 0);
      nb   = 8'($urandom);
      run_frame(idx, b, mode, hold, nb);
      pend = hold;
      pidx = idx;
      pb   = nb;
    end
    if (pend) run_frame(pidx, pb, 1, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx_ctrl.md
SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, byte offered.
REQ-005 SHALL have port in_data, input, 8, byte to transmit, MSB first.
REQ-006 SHALL have port in_ready, output, 1, controller can accept a byte.
REQ-007 SHALL have port sin, input, 1, serial receive data, full-duplex.
REQ-008 SHALL have port sout, output, 1, serial transmit data.
REQ-009 SHALL have port busy, output, 1, frame in progress.
REQ-010 SHALL have port done, output, 1, one-cycle frame-complete pulse.
REQ-011 SHALL have port rx_data, output, 8, last received byte.

Function
REQ-012 SHALL implement states IDLE, SHIFT, PARITY, DONE.
REQ-013 In IDLE: in_ready=1, busy=0, sout=1; in all other states: in_ready=0, busy=1.
REQ-014 Handshake: transfer occurs on an edge with in_valid&&in_ready; in_valid in other states is ignored (no queuing).
REQ-015 On transfer edge: the 8-bit shift register loads in_data; state->SHIFT; bit_cnt=0; div_cnt=0.
REQ-016 In SHIFT: sout = shift register bit 7; each bit held exactly CLKS_PER_BIT cycles.
REQ-017 At div_cnt==CLKS_PER_BIT-1: shift left one place, sin sampled into bit 0, div_cnt=0, bit_cnt+1; otherwise div_cnt+1.
REQ-018 After the 8th shift: state->PARITY if enabled (REQ-025), else DONE.
REQ-019 In DONE (exactly one cycle): done=1, sout=1; rx_data <= shift register contents (8 bits received, first received in bit 7); next state IDLE.
REQ-020 Timing: without parity, done is high in the cycle starting 8*CLKS_PER_BIT edges after the transfer edge; the next transfer can occur no earlier than 2 edges later.
REQ-021 CLKS_PER_BIT=1: one shift every cycle; no idle cycles inside a frame.
REQ-022 rx_data holds its value until the next DONE.

Reset
REQ-023 While rst_n=0 at an edge: state=IDLE, counters=0, rx_data=8'h00, done=0, busy=0, sout=1; the shift register is loaded with 8'h00.
REQ-024 Reset mid-frame SHALL abort the frame with no done pulse; rx_data is cleared to 8'h00; a new transfer can occur on the first edge with rst_n=1.

Configuration
REQ-025 Macro SERIAL_TX_CTRL_PARITY_EN defined: PARITY state lasts CLKS_PER_BIT cycles, sout = even parity (XOR) of the transmitted byte latched at transfer, done delayed by CLKS_PER_BIT cycles.
REQ-026 Macro undefined: no PARITY state, no parity register; SHIFT goes directly to DONE.

Structure
REQ-027 Package serial_tx_pkg SHALL hold: state enum type, BYTE_W=8, SOUT_IDLE=1'b1.
REQ-028 SHALL instantiate sub-module shiftreg (8-bit, synchronous load/shift-left, sin into bit 0, no reset); the controller drives its load, d and sin.
REQ-029 Divider counter width SHALL be $clog2(CLKS_PER_BIT+1); bit counter width SHALL be 4 bits.

Verification
REQ-030 CLKS_PER_BIT=4, in_data=8'hA5, sin tied 0 -> sout 1,0,1,0,0,1,0,1, each bit for 4 cycles; done 32 edges after the transfer edge; rx_data=8'h00.
REQ-031 CLKS_PER_BIT=1, in_data=8'h3C, sin driven by sout looped back -> done after 8 edges; rx_data=8'h3C.
REQ-032 in_valid held high continuously, bytes 8'h01 then 8'h02 -> second transfer exactly 2 edges after done; in_valid ignored while busy=1.
REQ-033 rst_n=0 for one edge during bit 3 of 8'hFF -> no done pulse; sout=1, busy=0, rx_data=8'h00; next byte transmits correctly.
REQ-034 SERIAL_TX_CTRL_PARITY_EN defined, CLKS_PER_BIT=2, in_data=8'h07 -> parity bit sout=1 for 2 cycles; done 18 edges after the transfer edge.
